ppu_vram_arbiter: RTL

PPU_VRAM_ARBITER -- requirements
Module: ppu_vram_arbiter

---
 rtl/ppu_pkg.sv | 21 ++
 rtl/ppu_vram_arbiter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/ppu_pkg.sv
// Shared types and constants for the PPU VRAM bus arbiter.
// Holds the access FSM states, requester identities and bus widths.
package ppu_pkg;

    localparam int VRAM_AW          = 14;
    localparam int VRAM_DW          = 8;
    localparam int STARVE_W         = 4;
    localparam int STARVE_LIMIT_DEF = 15;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } state_e;

    typedef enum logic {
        OWN_REND,
        OWN_CPU
    } owner_e;

endpackage

// File: rtl/ppu_vram_arbiter.sv
// Shares the external PPU VRAM bus between the render fetcher and CPU PPUDATA
// accesses; every access is one address-latch cycle followed by one data cycle.
module ppu_vram_arbiter
    import ppu_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               rendering,

    input  logic               rend_req,
    input  logic [VRAM_AW-1:0] rend_addr,
    output logic               rend_gnt,
    output logic [VRAM_DW-1:0] rend_rdata,
    output logic               rend_rvalid,

    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [VRAM_AW-1:0] cpu_addr,
    input  logic [VRAM_DW-1:0] cpu_wdata,
    output logic               cpu_gnt,
    output logic [VRAM_DW-1:0] cpu_rdata,
    output logic               cpu_done,

    output logic [VRAM_AW-1:0] PPU_BUS_ADDR,
    output logic [VRAM_DW-1:0] PPU_DATA_OUT,
    input  logic [VRAM_DW-1:0] PPU_DATA_IN,
    output logic               PPU_ALE,
    output logic               PPU_READ,
    output logic               PPU_WRITE
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    state_e               state_q;
    owner_e               owner_q;
    logic                 we_q;
    logic [VRAM_DW-1:0]   wdata_q;
    logic [VRAM_AW-1:0]   bus_addr_q;
    logic [VRAM_DW-1:0]   dout_q;
    logic                 ale_q, read_q, write_q;
    logic                 rend_gnt_q, rend_rvalid_q, cpu_gnt_q, cpu_done_q;
    logic [VRAM_DW-1:0]   rend_rdata_q, cpu_rdata_q;
    logic [STARVE_W-1:0]  starve_q, starve_d;
    logic                 cpu_wins, rend_wins;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        cpu_wins  = cpu_req && ((starve_q == LIMIT) || !rendering || !rend_req);
        rend_wins = rend_req && !cpu_wins;

        starve_d = starve_q;
        if (!cpu_req || cpu_gnt_q) begin
            starve_d = '0;
        end else if (starve_q != LIMIT) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q       <= IDLE;
            owner_q       <= OWN_REND;
            we_q          <= 1'b0;
            wdata_q       <= '0;
            bus_addr_q    <= '0;
            dout_q        <= '0;
            ale_q         <= 1'b0;
            read_q        <= 1'b0;
            write_q       <= 1'b0;
            rend_gnt_q    <= 1'b0;
            rend_rvalid_q <= 1'b0;
            cpu_gnt_q     <= 1'b0;
            cpu_done_q    <= 1'b0;
            rend_rdata_q  <= '0;
            cpu_rdata_q   <= '0;
            starve_q      <= '0;
        end else begin
            starve_q      <= starve_d;
            ale_q         <= 1'b0;
            read_q        <= 1'b0;
            write_q       <= 1'b0;
            dout_q        <= '0;
            rend_gnt_q    <= 1'b0;
            cpu_gnt_q     <= 1'b0;
            rend_rvalid_q <= 1'b0;
            cpu_done_q    <= 1'b0;

            // Completion of the access whose data cycle ends at this edge.
            if (state_q == DATA) begin
                if (owner_q == OWN_CPU) begin
                    cpu_done_q <= 1'b1;
                    if (!we_q) cpu_rdata_q <= PPU_DATA_IN;
                end else begin
                    rend_rvalid_q <= 1'b1;
                    rend_rdata_q  <= PPU_DATA_IN;
                end
            end

            case (state_q)
                ADDR: begin
                    state_q <= DATA;
                    read_q  <= !we_q;
                    write_q <= we_q;
                    dout_q  <= we_q ? wdata_q : '0;
                end
                default: begin
                    // IDLE and DATA are both arbitration points, giving back-to-back accesses.
                    if (cpu_wins) begin
                        state_q    <= ADDR;
                        owner_q    <= OWN_CPU;
                        we_q       <= cpu_we;
                        wdata_q    <= cpu_wdata;
                        bus_addr_q <= cpu_addr;
                        ale_q      <= 1'b1;
                        cpu_gnt_q  <= 1'b1;
                    end else if (rend_wins) begin
                        state_q    <= ADDR;
                        owner_q    <= OWN_REND;
                        we_q       <= 1'b0;
                        wdata_q    <= '0;
                        bus_addr_q <= rend_addr;
                        ale_q      <= 1'b1;
                        rend_gnt_q <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign rend_gnt     = rend_gnt_q;
    assign rend_rdata   = rend_rdata_q;
    assign rend_rvalid  = rend_rvalid_q;
    assign cpu_gnt      = cpu_gnt_q;
    assign cpu_rdata    = cpu_rdata_q;
    assign cpu_done     = cpu_done_q;
    assign PPU_BUS_ADDR = bus_addr_q;
    assign PPU_DATA_OUT = dout_q;
    assign PPU_ALE      = ale_q;
    assign PPU_READ     = read_q;
    assign PPU_WRITE    = write_q;

endmodule
